// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized input, mid-bit sampling, one-byte holding register with ready/valid.
// Define UART_RX_PARITY_EN for 8E1 framing (even parity); default build is 8N1.
module uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun_err
);

    // state  | meaning
    // IDLE   | line idle, waiting for a high-to-low edge
    // START  | half-bit wait, then confirm start bit is still low
    // DATA   | sampling 8 data bits, LSB first
    // PARITY | sampling even-parity bit (parity build only)
    // STOP   | sampling stop bit, deliver or flag the byte
    // BREAK  | line held low after a framing error, wait for high
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        rx_meta, rx_s, rx_d;
    logic [1:0]  sync_age;
    logic        byte_done, frame_set;
`ifdef UART_RX_PARITY_EN
    logic        par_bit, par_nxt, parity_set;
`endif

    // rx_d is held low until the synchronizer has flushed its reset value, so a line
    // that is already low when reset releases is never mistaken for a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_d     <= 1'b0;
            sync_age <= 2'd0;
        end else begin
            rx_meta <= rx_pin;
            rx_s    <= rx_meta;
            rx_d    <= (sync_age == 2'd2) ? rx_s : 1'b0;
            if (sync_age != 2'd2)
                sync_age <= sync_age + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        byte_done   = 1'b0;
        frame_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt     = par_bit;
        parity_set  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_d && !rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = HALF_CNT;
                end
            end
            START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        cnt_nxt     = FULL_CNT;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    cnt_nxt     = FULL_CNT;
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == '0) begin
                    par_nxt   = rx_s;
                    cnt_nxt   = FULL_CNT;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        frame_set = 1'b1;
                        state_nxt = BREAK;
                    end else begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shreg, par_bit})
                            parity_set = 1'b1;
                        else
                            byte_done = 1'b1;
`else
                        byte_done = 1'b1;
`endif
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            BREAK: begin
                if (rx_s)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new byte always wins over a same-cycle handshake; it only counts as an
    // overrun when the old byte was neither consumed before nor in this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= frame_set;
            overrun_err <= byte_done && rx_valid && !rx_ready;
            if (byte_done) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_err <= 1'b0;
        else
            parity_err <= parity_set;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed corner cases plus random frames
// checked against a byte-level model of what the receiver should deliver.
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_pin;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err, parity_err, overrun_err;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk),
        .rst(rst),
        .rx_pin(rx_pin),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .parity_err(parity_err),
        .overrun_err(overrun_err)
    );

    int total = 0;
    int bad = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int valid_cyc = 0, frame_cnt = 0, parity_cnt = 0, overrun_cnt = 0;
    int multi_cnt = 0, wide_cnt = 0;
    logic prev_fe = 1'b0, prev_pe = 1'b0, prev_oe = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_fe = 1'b0;
            prev_pe = 1'b0;
            prev_oe = 1'b0;
        end else begin
            if (rx_valid && rx_ready)
                got_q.push_back(rx_data);
            valid_cyc   += int'(rx_valid);
            frame_cnt   += int'(frame_err);
            parity_cnt  += int'(parity_err);
            overrun_cnt += int'(overrun_err);
            if (int'(frame_err) + int'(parity_err) + int'(overrun_err) > 1)
                multi_cnt++;
            if ((frame_err && prev_fe) || (parity_err && prev_pe) || (overrun_err && prev_oe))
                wide_cnt++;
            prev_fe = frame_err;
            prev_pe = parity_err;
            prev_oe = overrun_err;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] last_got();
        return (got_q.size() > 0) ? {24'h0, got_q[$]} : 32'hFFFF_FFFF;
    endfunction

    task automatic drive(input logic b, input int n);
        rx_pin = b;
        repeat (n) @(posedge clk);
    endtask

    // rst_bit >= 0 pulses reset for 3 cycles at the start of that data bit
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                              input int rst_bit);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                rx_pin = d[i];
                rst = 1'b1;
                repeat (3) @(posedge clk);
                rst = 1'b0;
                repeat (CPB - 3) @(posedge clk);
            end else begin
                drive(d[i], CPB);
            end
        end
`ifdef UART_RX_PARITY_EN
        drive((^d) ^ par_flip, CPB);
`else
        if (par_flip) drive(1'b1, 0);
`endif
        drive(stop_bit, CPB);
    endtask

    int v0, f0, p0, o0, n0;

    task automatic snap();
        v0 = valid_cyc;
        f0 = frame_cnt;
        p0 = parity_cnt;
        o0 = overrun_cnt;
        n0 = got_q.size();
    endtask

    initial begin
        rst = 1'b1;
        rx_pin = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(rx_valid), 0);
        check_eq("rst_data", 32'(rx_data), 0);
        check_eq("rst_errs", 32'({frame_err, parity_err, overrun_err}), 0);
        @(negedge clk) rst = 1'b0;
        drive(1'b1, 2 * CPB);

        // single byte, consumer always ready
        rx_ready = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        drive(1'b1, CPB);
        check_eq("a5_valid_cycles", 32'(valid_cyc - v0), 1);
        check_eq("a5_count", 32'(got_q.size() - n0), 1);
        check_eq("a5_data", last_got(), 32'hA5);
        check_eq("a5_errs", 32'((frame_cnt - f0) + (parity_cnt - p0) + (overrun_cnt - o0)), 0);

        // back-to-back with no consumer: second byte overwrites
        rx_ready = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        drive(1'b1, CPB);
        #1;
        check_eq("ovr_data", 32'(rx_data), 32'hC3);
        check_eq("ovr_valid", 32'(rx_valid), 1);
        check_eq("ovr_pulses", 32'(overrun_cnt - o0), 1);
        check_eq("ovr_none_taken", 32'(got_q.size() - n0), 0);

        // asynchronous reset clears the holding register between clock edges
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("async_rst_valid", 32'(rx_valid), 0);
        check_eq("async_rst_data", 32'(rx_data), 0);
        @(negedge clk) rst = 1'b0;
        rx_ready = 1'b1;
        drive(1'b1, 2 * CPB);

        // stop bit low, then a long break, then a normal byte
        snap();
        send_frame(8'h55, 1'b0, 1'b0, -1);
        drive(1'b0, 39 * CPB);
        drive(1'b1, 2 * CPB);
        check_eq("brk_frame_err", 32'(frame_cnt - f0), 1);
        check_eq("brk_no_valid", 32'(valid_cyc - v0), 0);
        check_eq("brk_other_errs", 32'((parity_cnt - p0) + (overrun_cnt - o0)), 0);
        send_frame(8'h12, 1'b1, 1'b0, -1);
        drive(1'b1, CPB);
        check_eq("brk_next_data", last_got(), 32'h12);
        check_eq("brk_next_count", 32'(got_q.size() - n0), 1);

        // short low glitch is a false start
        snap();
        drive(1'b0, 5);
        drive(1'b1, 3 * CPB);
        check_eq("glitch_no_valid", 32'(valid_cyc - v0), 0);
        check_eq("glitch_no_errs", 32'((frame_cnt - f0) + (parity_cnt - p0) + (overrun_cnt - o0)), 0);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        drive(1'b1, CPB);
        check_eq("glitch_next_data", last_got(), 32'hFF);

        // reset in the middle of a frame aborts it
        snap();
        send_frame(8'h81, 1'b1, 1'b0, 3);
        drive(1'b1, 2 * CPB);
        check_eq("midrst_nothing", 32'(got_q.size() - n0), 0);
        check_eq("midrst_no_errs", 32'((frame_cnt - f0) + (parity_cnt - p0) + (overrun_cnt - o0)), 0);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        drive(1'b1, CPB);
        check_eq("midrst_next_count", 32'(got_q.size() - n0), 1);
        check_eq("midrst_next_data", last_got(), 32'h7E);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h03, 1'b1, 1'b0, -1);
        drive(1'b1, CPB);
        check_eq("par_ok_data", last_got(), 32'h03);
        check_eq("par_ok_count", 32'(got_q.size() - n0), 1);
        snap();
        send_frame(8'h03, 1'b1, 1'b1, -1);
        drive(1'b1, CPB);
        check_eq("par_bad_pulse", 32'(parity_cnt - p0), 1);
        check_eq("par_bad_no_valid", 32'(valid_cyc - v0), 0);
        check_eq("par_bad_no_frame", 32'(frame_cnt - f0), 0);
`endif

        // random frames against the byte-level model
        begin
            int exp_frame, exp_parity;
            got_q.delete();
            exp_q.delete();
            snap();
            exp_frame = 0;
            exp_parity = 0;
            for (int k = 0; k < 24; k++) begin
                logic [7:0] d;
                logic stop_ok, pflip;
                d = 8'($urandom);
                stop_ok = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
                pflip = ($urandom_range(0, 3) == 0);
`else
                pflip = 1'b0;
`endif
                if (!stop_ok)
                    exp_frame++;
                else if (pflip)
                    exp_parity++;
                else
                    exp_q.push_back(d);
                send_frame(d, stop_ok, pflip, -1);
                drive(1'b1, int'($urandom_range(4, 3 * CPB)));
                check_eq("rnd_count", 32'(got_q.size()), 32'(exp_q.size()));
            end
            for (int k = 0; k < exp_q.size(); k++)
                check_eq("rnd_data", (k < got_q.size()) ? {24'h0, got_q[k]} : 32'hFFFF_FFFF,
                         {24'h0, exp_q[k]});
            check_eq("rnd_frame_errs", 32'(frame_cnt - f0), 32'(exp_frame));
            check_eq("rnd_parity_errs", 32'(parity_cnt - p0), 32'(exp_parity));
            check_eq("rnd_overruns", 32'(overrun_cnt - o0), 0);
        end

        check_eq("errs_exclusive", 32'(multi_cnt), 0);
        check_eq("errs_single_cycle", 32'(wide_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per serial bit (50 MHz / 115200 baud); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_pin  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port rx_data  output  8  last received byte.
REQ-006 SHALL have port rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  consumer accepts rx_data this cycle.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse, parity mismatch.
REQ-010 SHALL have port overrun_err  output  1  one-cycle pulse, unconsumed byte overwritten.

Function
REQ-011 SHALL pass rx_pin through a 2-flop synchronizer (reset value 1) before any use; all timing below refers to the synchronized signal rx_s.
REQ-012 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK with a 16-bit bit-timing counter and a 3-bit bit index.
REQ-013 IDLE: on rx_s high-to-low transition SHALL go to START and load the counter for a half-bit wait (CLKS_PER_BIT/2, integer division).
REQ-014 START: at half-bit point SHALL resample rx_s; low -> DATA with full-bit count; high -> false start, back to IDLE, no output or error.
REQ-015 DATA: SHALL sample one bit every CLKS_PER_BIT cycles, LSB first, into a shift register; after bit 7 go to PARITY (macro on) or STOP (macro off).
REQ-016 STOP: at the sample point, rx_s high -> byte complete, return to IDLE; rx_s low -> frame_err pulse, byte discarded, go to BREAK.
REQ-017 BREAK: SHALL stay until rx_s is high, then IDLE; no new start detected while in BREAK.
REQ-018 On byte complete, rx_data and rx_valid=1 SHALL update on the clock edge after the stop-bit sample (latency 1 cycle from stop sample).
REQ-019 rx_valid SHALL stay high until a cycle with rx_valid=1 and rx_ready=1; it clears on the following edge; rx_ready while rx_valid=0 has no effect.
REQ-020 Byte complete while rx_valid=1 and rx_ready=0 SHALL overwrite rx_data, keep rx_valid=1, and pulse overrun_err for one cycle.
REQ-021 Byte complete in the same cycle as an accepting handshake SHALL load the new byte, keep rx_valid=1, no overrun_err.
REQ-022 rx_data SHALL remain stable while rx_valid=1 except per REQ-020/021.
REQ-023 Error outputs SHALL be single-cycle pulses, never asserted together.

Reset
REQ-024 On rst high, asynchronously: state IDLE, counters 0, synchronizer flops 1, rx_data 8'h00, rx_valid 0, all error outputs 0.
REQ-025 Reset mid-frame SHALL abort the frame with no output; after release, reception resumes only on a new high-to-low edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: frame is start, 8 data, even-parity bit, stop; PARITY state samples one bit; mismatch -> parity_err pulse at stop-bit completion, byte discarded, rx_valid unchanged; stop-low error takes precedence (frame_err only).
REQ-027 Macro UART_RX_PARITY_EN undefined: PARITY state absent, frame is 8N1, parity_err tied 0.

Verification (bench uses CLKS_PER_BIT=16)
REQ-028 8N1 byte 8'hA5, rx_ready=1 -> rx_valid for exactly 1 cycle, rx_data=8'hA5, no errors.
REQ-029 0x3C then 0xC3 back-to-back, rx_ready=0 -> rx_data=8'hC3, rx_valid=1, one overrun_err pulse at the second byte.
REQ-030 Stop bit held low, byte 8'h55 -> frame_err pulse, rx_valid stays 0; line held low 40 bit times then high, then byte 8'h12 -> rx_data=8'h12.
REQ-031 Low glitch of 5 cycles on idle line -> no rx_valid, no errors, next byte 8'hFF received correctly.
REQ-032 rst asserted at data bit 3 of 8'h81, released, then byte 8'h7E -> only 8'h7E delivered.
REQ-033 UART_RX_PARITY_EN: 8'h03 with parity 0 -> rx_valid, rx_data=8'h03; with parity 1 -> parity_err pulse, rx_valid stays 0.
